alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Multi-cycle multiply/divide sequencer for the CPU. It borrows the shared 32-bit ALU (add/sub group) through a req/gnt handshake.
//  Iterates shift-add multiply or restoring divide, one ALU op per granted cycle. Results land in HI/LO.
//  Sits beside the EX stage; the pipeline stalls on busy, and the EX-side mux hands the ALU over when alu_gnt=1.
// PARAMETERS
//  XLEN     32         operand width; only 32 is supported
//  ALU_ADD  6'b000000  ALUFun code for add (add/sub group, bit0=0)
//  ALU_SUB  6'b000001  ALUFun code for subtract (bit0=1)
// PORTS
//  clk       in   1   clock, rising edge
//  reset     in   1   asynchronous, active-low reset
//  start     in   1   launch operation; sampled only in IDLE
//  op        in   2   op[0]: 0=MUL, 1=DIV; op[1]: 1=signed
//  opa       in   32  multiplicand / dividend, sampled with start
//  opb       in   32  multiplier / divisor, sampled with start
//  busy      out  1   operation in flight (stall request)
//  done      out  1   one-cycle pulse: hi/lo valid
//  hi        out  32  MUL: product[63:32]; DIV: remainder
//  lo        out  32  MUL: product[31:0]; DIV: quotient
//  alu_req   out  1   sequencer needs the ALU this cycle
//  alu_gnt   in   1   ALU owned by sequencer this cycle
//  alu_a     out  32  ALU operand A
//  alu_b     out  32  ALU operand B
//  alu_fun   out  6   ALUFun (ALU_ADD or ALU_SUB only)
//  alu_sign  out  1   tied 0 (unsigned add/sub)
//  alu_z     in   32  ALU result, combinational, same cycle
// BEHAVIOUR
//  Reset: IDLE; busy=0, done=0, alu_req=0, hi=lo=0, internal count=0. Reset mid-op aborts; no done.
//  FSM: IDLE -> [NEG_IN] -> ITER -> [NEG_LO -> NEG_HI] -> DONE -> IDLE.
//  IDLE: start=1 latches opa/opb/op; busy=1 from the next cycle. start while busy is ignored.
//  DIV with opb==0: IDLE->DONE, no ALU use; lo=32'hFFFFFFFF, hi=opa (raw). done 2 cycles after start.
//  alu_req=1 in every ALU-using state. A state advances, and a result is registered, only on an edge with alu_gnt=1.
//  gnt=0 holds all state. alu_a/b/fun stay stable until granted.
//  ITER: exactly 32 granted cycles, 5-bit counter; wraps 31->0 on leaving ITER.
//   MUL: if lo[0], alu = hi+B (ADD), else result=hi (req still 1).
//    carry = (hi[31]&B[31]) | ((hi[31]|B[31]) & ~z[31]); {hi,lo} <= {carry,z,lo[31:1]}.
//   DIV: r' = {rem[30:0], dvd[31]}, alu = r' - B (SUB).
//    borrow = (~r'[31]&B[31]) | ((~r'[31]|B[31]) & z[31]).
//    accept if (rem[31] | ~borrow): rem<=z, q bit=1; else rem<=r', q bit=0.
//  DONE: done=1 for one cycle, busy=0 in the same cycle. State returns to IDLE. hi/lo hold until the next accepted start.
//  Unsigned latency: start edge -> done = 1 + 32 granted cycles + 1.
//  The ALU sees only add/sub codes. No overflow is reported (MIPS MULT/DIV semantics).
// CONFIGURATION
//  ALU_MULDIV_SIGNED_EN defined:
//   op[1]=1 inserts NEG_IN: negative opa, then opb, are negated via ALU (0-x, SUB), 1 granted cycle each; positives skip.
//   Post: MUL negates the 64-bit product if the signs differ.
//    NEG_LO: lo=0-lo.
//    NEG_HI: alu=~hi + (lo_old==0) via ADD.
//   DIV: quotient negated if the signs differ; remainder negated if the dividend is negative.
//   Divide-by-zero path unchanged.
//  Undefined: op[1] ignored; all ops unsigned; NEG_* states absent.
// TESTING
//  MULTU FFFFFFFF*FFFFFFFF, gnt=1 -> done 34 cycles after start; hi=FFFFFFFE lo=00000001.
//  DIVU 100/7, gnt=1 -> lo=0000000E hi=00000002; busy low on the done cycle.
//  DIVU 00001234/0 -> done 2 cycles after start; lo=FFFFFFFF hi=00001234; alu_req never 1.
//  MULTU 3*5, gnt toggling 1010... -> done only after 32 granted ITER cycles; lo=0000000F hi=0.
//   alu_a/b stable while gnt=0.
//  reset low mid-ITER of DIVU -> busy=0, hi=lo=0 immediately, no done.
//   start pulsed while busy -> ignored, result unaffected.
//  With ALU_MULDIV_SIGNED_EN: DIV FFFFFFF9/2 -> lo=FFFFFFFD hi=FFFFFFFF; MULT FFFFFFFD*5 -> hi=FFFFFFFF lo=FFFFFFF1.
//   Without it: DIV FFFFFFF9/2 -> lo=7FFFFFFC hi=00000001.

Source files
------------

// File: rtl/alu_muldiv_seq_if.sv
// Bundle between the EX stage and the multiply/divide sequencer:
// command/result signals plus the borrowed-ALU port.
interface alu_muldiv_seq_if;
  // Command: start is accepted only while the sequencer is idle; done pulses once with hi/lo valid.
  // ALU borrow: alu_req/alu_gnt act as valid/ready. An ALU op completes on a rising edge where
  // both are high; while alu_req=1 and alu_gnt=0, alu_a/alu_b/alu_fun are held unchanged.
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        alu_req;
  logic        alu_gnt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic [31:0] alu_z;

  modport master (
    output start, op, opa, opb, alu_gnt, alu_z,
    input  busy, done, hi, lo, alu_req, alu_a, alu_b, alu_fun, alu_sign
  );

  modport slave (
    input  start, op, opa, opb, alu_gnt, alu_z,
    output busy, done, hi, lo, alu_req, alu_a, alu_b, alu_fun, alu_sign
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle shift-add multiply / restoring divide on the shared ALU, results in HI/LO.
// Optional signed ops (op[1]) are enabled by defining ALU_MULDIV_SIGNED_EN.
module alu_muldiv_seq #(
  parameter int          XLEN    = 32,
  parameter logic [5:0]  ALU_ADD = 6'b000000,
  parameter logic [5:0]  ALU_SUB = 6'b000001
) (
  input  logic             clk,
  input  logic             reset,
  alu_muldiv_seq_if.slave  bus,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NEG_IN = 3'd1,
    S_ITER   = 3'd2,
    S_NEG_LO = 3'd3,
    S_NEG_HI = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic [XLEN-1:0]   b_q;
  logic [4:0]        cnt;
  logic              is_div;
  logic              busy_q;
  logic              done_q;

`ifdef ALU_MULDIV_SIGNED_EN
  logic              neg_a;
  logic              neg_b;
  logic              neg_lo;
  logic              neg_hi;
  logic              lo_zero;
`else
  logic              unused_op;
  assign unused_op = bus.op[1];
`endif

  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [5:0]        alu_fun;
  logic [XLEN-1:0]   r_shift;
  logic [XLEN-1:0]   mul_sum;
  logic              mul_carry;
  logic              borrow;
  logic              accept;

  // Operand selection depends only on registered state, so it is stable while ungranted.
  always_comb begin
    r_shift = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    alu_a   = hi_q;
    alu_b   = b_q;
    alu_fun = ALU_ADD;
    case (state)
      S_ITER: begin
        if (is_div) begin
          alu_a   = r_shift;
          alu_fun = ALU_SUB;
        end
      end
`ifdef ALU_MULDIV_SIGNED_EN
      S_NEG_IN: begin
        alu_a   = '0;
        alu_fun = ALU_SUB;
        // MUL keeps opa in b_q and opb in lo_q; DIV keeps opa in lo_q and opb in b_q.
        if (neg_a) alu_b = is_div ? lo_q : b_q;
        else       alu_b = is_div ? b_q  : lo_q;
      end
      S_NEG_LO: begin
        alu_a   = '0;
        alu_b   = lo_q;
        alu_fun = ALU_SUB;
      end
      S_NEG_HI: begin
        alu_a   = ~hi_q;
        alu_b   = {{(XLEN-1){1'b0}}, is_div | lo_zero};
        alu_fun = ALU_ADD;
      end
`endif
      default: ;
    endcase
  end

  assign mul_sum   = lo_q[0] ? bus.alu_z : hi_q;
  assign mul_carry = lo_q[0] & ((hi_q[XLEN-1] & b_q[XLEN-1]) |
                                ((hi_q[XLEN-1] | b_q[XLEN-1]) & ~bus.alu_z[XLEN-1]));
  assign borrow    = (~r_shift[XLEN-1] & b_q[XLEN-1]) |
                     ((~r_shift[XLEN-1] | b_q[XLEN-1]) & bus.alu_z[XLEN-1]);
  // hi_q[31] set means the shifted remainder overflowed 32 bits, so it always exceeds B.
  assign accept    = hi_q[XLEN-1] | ~borrow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_MULDIV_SIGNED_EN
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      lo_zero <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            is_div <= bus.op[0];
            busy_q <= 1'b1;
            cnt    <= '0;
            hi_q   <= '0;
            if (bus.op[0]) begin
              lo_q <= bus.opa;
              b_q  <= bus.opb;
            end else begin
              lo_q <= bus.opb;
              b_q  <= bus.opa;
            end
            if (bus.op[0] && (bus.opb == '0)) begin
              hi_q  <= bus.opa;
              lo_q  <= '1;
              state <= S_DONE;
            end else begin
`ifdef ALU_MULDIV_SIGNED_EN
              neg_a  <= bus.op[1] & bus.opa[XLEN-1];
              neg_b  <= bus.op[1] & bus.opb[XLEN-1];
              neg_lo <= bus.op[1] & (bus.opa[XLEN-1] ^ bus.opb[XLEN-1]);
              neg_hi <= bus.op[1] & (bus.op[0] ? bus.opa[XLEN-1]
                                               : (bus.opa[XLEN-1] ^ bus.opb[XLEN-1]));
              state  <= (bus.op[1] & (bus.opa[XLEN-1] | bus.opb[XLEN-1])) ? S_NEG_IN : S_ITER;
`else
              state  <= S_ITER;
`endif
            end
          end
        end
`ifdef ALU_MULDIV_SIGNED_EN
        S_NEG_IN: begin
          if (bus.alu_gnt) begin
            if (neg_a) begin
              neg_a <= 1'b0;
              if (is_div) lo_q <= bus.alu_z;
              else        b_q  <= bus.alu_z;
              if (!neg_b) state <= S_ITER;
            end else begin
              neg_b <= 1'b0;
              if (is_div) b_q  <= bus.alu_z;
              else        lo_q <= bus.alu_z;
              state <= S_ITER;
            end
          end
        end
`endif
        S_ITER: begin
          if (bus.alu_gnt) begin
            cnt <= cnt + 5'd1;
            if (is_div) begin
              hi_q <= accept ? bus.alu_z : r_shift;
              lo_q <= {lo_q[XLEN-2:0], accept};
            end else begin
              {hi_q, lo_q} <= {mul_carry, mul_sum, lo_q[XLEN-1:1]};
            end
            if (cnt == 5'd31) begin
`ifdef ALU_MULDIV_SIGNED_EN
              if (neg_lo)      state <= S_NEG_LO;
              else if (neg_hi) state <= S_NEG_HI;
              else             state <= S_DONE;
`else
              state <= S_DONE;
`endif
            end
          end
        end
`ifdef ALU_MULDIV_SIGNED_EN
        S_NEG_LO: begin
          if (bus.alu_gnt) begin
            lo_q    <= bus.alu_z;
            lo_zero <= (lo_q == '0);
            state   <= neg_hi ? S_NEG_HI : S_DONE;
          end
        end
        S_NEG_HI: begin
          if (bus.alu_gnt) begin
            hi_q  <= bus.alu_z;
            state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.alu_req  = (state == S_NEG_IN) || (state == S_ITER) ||
                        (state == S_NEG_LO) || (state == S_NEG_HI);
  assign bus.alu_a    = alu_a;
  assign bus.alu_b    = alu_b;
  assign bus.alu_fun  = alu_fun;
  assign bus.alu_sign = 1'b0;
  assign state_dbg    = state;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: directed vectors, arithmetic reference model, per-cycle compare process.
// Honours ALU_MULDIV_SIGNED_EN the same way as the design.
module tb_alu_muldiv_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_dbg;

  alu_muldiv_seq_if bus ();

  alu_muldiv_seq dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Shared ALU stand-in: add/sub group selected by ALUFun bit 0.
  assign bus.alu_z = bus.alu_fun[0] ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);

`ifdef ALU_MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  int          gnt_cnt  = 0;
  int          req_cnt  = 0;
  logic        hold_valid = 1'b0;
  logic [31:0] hold_a, hold_b;
  logic [5:0]  hold_fun;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} straight from the arithmetic definition.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa64, sb64, r64, q64;
    logic        [63:0] res;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    if (!op[0]) begin
      if (SIGNED_EN && op[1]) res = sa64 * sb64;
      else                    res = {32'd0, a} * {32'd0, b};
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFFFFFF};
    end else if (SIGNED_EN && op[1]) begin
      q64 = sa64 / sb64;
      r64 = sa64 % sb64;
      res = {r64[31:0], q64[31:0]};
    end else begin
      res = {a % b, a / b};
    end
    return res;
  endfunction

  // Granted ALU operations an op needs: negations in, 32 iterations, sign fix-ups out.
  function automatic int alu_ops(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    bit sa, sb;
    if (op[0] && b == 32'd0) return 0;
    sa = SIGNED_EN && op[1] && a[31];
    sb = SIGNED_EN && op[1] && b[31];
    n  = 32 + int'(sa) + int'(sb);
    if (!op[0]) n += (sa ^ sb) ? 2 : 0;
    else        n += int'(sa ^ sb) + int'(sa);
    return n;
  endfunction

  // Compare process: ALU hand-over rules every cycle, results whenever done pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.alu_req) begin
        req_cnt++;
        if (bus.alu_gnt) gnt_cnt++;
        check("alu_fun_legal", {58'd0, bus.alu_fun[5:1]}, 64'd0);
        check("alu_sign_zero", {63'd0, bus.alu_sign}, 64'd0);
      end
      if (hold_valid) begin
        check("alu_a_hold", {32'd0, bus.alu_a}, {32'd0, hold_a});
        check("alu_b_hold", {32'd0, bus.alu_b}, {32'd0, hold_b});
        check("alu_fun_hold", {58'd0, bus.alu_fun}, {58'd0, hold_fun});
      end
      hold_valid = bus.alu_req && !bus.alu_gnt;
      hold_a     = bus.alu_a;
      hold_b     = bus.alu_b;
      hold_fun   = bus.alu_fun;
      if (bus.done) begin
        check("busy_low_on_done", {63'd0, bus.busy}, 64'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", bus.hi, bus.lo);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("result_hi", {32'd0, bus.hi}, {32'd0, e[63:32]});
          check("result_lo", {32'd0, bus.lo}, {32'd0, e[31:0]});
        end
      end
    end else begin
      hold_valid = 1'b0;
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit toggle, input bit poke,
                        input logic [31:0] lit_hi, input logic [31:0] lit_lo);
    logic [63:0] m;
    int cycles, g0, r0, n_ops;
    bit seen;
    m = model(op, a, b);
    check("model_pin", m, {lit_hi, lit_lo});
    exp_q.push_back(m);
    n_ops = alu_ops(op, a, b);
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.op      = op;
    bus.opa     = a;
    bus.opb     = b;
    bus.alu_gnt = 1'b1;
    g0 = gnt_cnt;
    r0 = req_cnt;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      bus.start = 1'b0;
      if (poke && cycles == 5) begin
        bus.start = 1'b1;
        bus.op    = ~op;
        bus.opa   = 32'hDEADBEEF;
        bus.opb   = 32'h00000003;
      end
      if (bus.done) seen = 1'b1;
      else          check("busy_in_flight", {63'd0, bus.busy}, 64'd1);
      if (toggle) bus.alu_gnt = ~bus.alu_gnt;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles expected done", cycles);
    end
    check("granted_alu_ops", 64'(gnt_cnt - g0), 64'(n_ops));
    if (!toggle) check("latency", 64'(cycles), 64'(n_ops + 2));
    if (n_ops == 0) check("div0_no_alu_req", 64'(req_cnt - r0), 64'd0);
    bus.start   = 1'b0;
    bus.alu_gnt = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.opa     = 32'd0;
    bus.opb     = 32'd0;
    bus.alu_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_alu_req", {63'd0, bus.alu_req}, 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_state", {61'd0, state_dbg}, 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    run_op(2'b01, 32'd100,      32'd7,        1'b0, 1'b1, 32'h00000002, 32'h0000000E);
    run_op(2'b01, 32'h00001234, 32'd0,        1'b0, 1'b0, 32'h00001234, 32'hFFFFFFFF);
    run_op(2'b00, 32'd3,        32'd5,        1'b1, 1'b0, 32'h00000000, 32'h0000000F);
    run_op(2'b00, 32'h12345678, 32'd0,        1'b0, 1'b0, 32'h00000000, 32'h00000000);
    run_op(2'b01, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'h00000000, 32'hFFFFFFFF);
    run_op(2'b01, 32'd5,        32'd9,        1'b1, 1'b0, 32'h00000005, 32'h00000000);
    run_op(2'b00, 32'h80000000, 32'd2,        1'b0, 1'b1, 32'h00000001, 32'h00000000);
    run_op(2'b01, 32'hFFFFFFF9, 32'd2,        1'b0, 1'b0, 32'h00000001, 32'h7FFFFFFC);
`ifdef ALU_MULDIV_SIGNED_EN
    run_op(2'b11, 32'hFFFFFFF9, 32'd2,        1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(2'b10, 32'hFFFFFFFD, 32'd5,        1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000, 32'h00000001);
    run_op(2'b11, 32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFD);
    run_op(2'b10, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 32'h00000000);
    run_op(2'b11, 32'h00001234, 32'd0,        1'b0, 1'b0, 32'h00001234, 32'hFFFFFFFF);
`else
    run_op(2'b11, 32'hFFFFFFF9, 32'd2,        1'b0, 1'b0, 32'h00000001, 32'h7FFFFFFC);
    run_op(2'b10, 32'hFFFFFFFD, 32'd5,        1'b0, 1'b0, 32'h00000004, 32'hFFFFFFF1);
`endif

    // Abort a DIVU mid-iteration: outputs clear at once and no done follows.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.opa   = 32'd100;
    bus.opb   = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_alu_req", {63'd0, bus.alu_req}, 64'd0);
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    check("abort_state", {61'd0, state_dbg}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("abort_idle_after", {63'd0, bus.busy}, 64'd0);
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
